fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register of the five-stage RISC-V core.
- Holds the program counter and drives the instruction-memory address.
- Selects between sequential and redirected PC. Registers the fetched instruction, PC and PC+4 into the decode stage, where the instruction opcode/funct fields feed the control unit.
- Honours stall and flush requests from the hazard unit and an instruction-memory ready signal.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address out, word and ready back.
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;

  // Fetch side drives the address and consumes the returned word.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  // Memory side returns the word at the presented address.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register of the five-stage core.
// Owns the PC, chooses sequential or redirected next PC, and registers the
// fetched word, its PC and PC+4 into decode under hazard-unit control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  input  logic                PCSrcE,
  input  logic [31:0]         PCTargetE,
  fetch_stage_if.master       imem,
  output logic [31:0]         PCF,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCD,
  output logic [31:0]         PCPlus4D,
  output logic                ValidD,
  output logic [31:0]         FetchCount
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INSTR_SZ = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] pc_target_aligned;
  logic [XLEN-1:0] pc_next;
  ifid_t           ifid_q;
  ifid_t           ifid_next;
  logic            capture_c;
  logic [XLEN-1:0] fetch_count_q;
  logic            unused_target_lsbs;

  // Redirect targets are word-aligned by dropping the low bits; no trap.
  assign unused_target_lsbs = ^PCTargetE[1:0];
  assign pc_target_aligned  = {PCTargetE[XLEN-1:2], 2'b00};

  // Sequential PC, wraps naturally modulo 2^32.
  assign pc_plus4_f = PCF + XLEN'(INSTR_SZ);

  // Next-PC select: redirect beats stall beats memory wait.
  always_comb begin
    pc_next = PCF;
    if (PCSrcE) begin
      pc_next = pc_target_aligned;
    end else if (StallF) begin
      pc_next = PCF;
    end else if (!imem.imem_ready) begin
      pc_next = PCF;
    end else begin
      pc_next = pc_plus4_f;
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= pc_next;
    end
  end

  // IF/ID next value: flush/redirect beats stall; no ready means a bubble.
  always_comb begin
    ifid_next = ifid_q;
    capture_c = 1'b0;
    if (FlushD || PCSrcE) begin
      ifid_next = IFID_BUBBLE;
    end else if (StallD) begin
      ifid_next = ifid_q;
    end else if (!imem.imem_ready) begin
      ifid_next = IFID_BUBBLE;
    end else begin
      ifid_next.instr    = imem.imem_rdata;
      ifid_next.pc       = PCF;
      ifid_next.pc_plus4 = pc_plus4_f;
      ifid_next.valid    = 1'b1;
      capture_c          = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= IFID_BUBBLE;
    end else begin
      ifid_q <= ifid_next;
    end
  end

  // Count real instructions accepted into decode; wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (capture_c) begin
      fetch_count_q <= fetch_count_q + XLEN'(1);
    end
  end

  assign imem.imem_addr = PCF;
  assign InstrD         = ifid_q.instr;
  assign PCD            = ifid_q.pc;
  assign PCPlus4D       = ifid_q.pc_plus4;
  assign ValidD         = ifid_q.valid;
  assign FetchCount     = fetch_count_q;

endmodule
